// File: rtl/io_intr_ctrl_if.sv
// io_intr_ctrl_if
//  Register port and CPU interrupt handshake of the I/O interrupt controller.
//  master: CPU / bus side (drives cfg_wr, cfg_addr, cfg_din, int_ack)
//  slave : controller side (drives cfg_dout, intr, int_id)
//  Signals:
//   cfg_wr    register write strobe
//   cfg_addr  register select: 0 MASK, 1 PEND, 2 TIMER_LOAD, 3 CTRL
//   cfg_din   register write data
//   cfg_dout  register read data, combinational from cfg_addr
//   int_ack   CPU acknowledge, rising-edge sensitive
//   intr      registered interrupt request
//   int_id    id of the source being serviced, valid while intr=1
interface io_intr_ctrl_if;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_din;
    logic [31:0] cfg_dout;
    logic        int_ack;
    logic        intr;
    logic [3:0]  int_id;

    modport master (
        output cfg_wr, cfg_addr, cfg_din, int_ack,
        input  cfg_dout, intr, int_id
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_din, int_ack,
        output cfg_dout, intr, int_id
    );
endinterface

// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl
//  Interrupt controller for the I/O memory subsystem. Latches rising edges of
//  the device request lines (and, optionally, an internal countdown timer),
//  masks them, and presents the lowest-index pending source to the CPU on the
//  intr/int_id handshake until int_ack rises.
//  Ports:
//   clk      system clock, all state changes on posedge
//   reset    synchronous, active-high reset
//   irq_src  device request lines, rising-edge sensitive
//   bus      io_intr_ctrl_if.slave: register port + intr/int_ack handshake
//  Build option:
//   IO_INTR_TIMER_EN  when defined, adds the countdown timer (source id
//                     NUM_SRC) with TIMER_LOAD (addr 2) and CTRL (addr 3).
//                     Otherwise addr 2/3 read 0 and ignore writes.
//
//  state  | meaning
//  IDLE   | waiting for an eligible (pending and unmasked) source
//  ASSERT | intr high with int_id frozen, waiting for int_ack rising edge
//  GAP    | one cycle of intr low so the CPU sees the deassert
module io_intr_ctrl #(
    parameter int NUM_SRC    = 4,
    parameter int TIMER_W    = 16,
    parameter int TIMER_INIT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    io_intr_ctrl_if.slave      bus
);

`ifdef IO_INTR_TIMER_EN
    localparam int NB = NUM_SRC + 1;
`else
    localparam int NB = NUM_SRC;
`endif

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ASSERT = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] irq_q;
    logic               ack_q;
    logic [NB-1:0]      mask;
    logic [NB-1:0]      pend;
    logic               intr_q;
    logic [3:0]         int_id_q;

    logic [NUM_SRC-1:0] rise;
    logic               ack_rise;
    logic [NB-1:0]      eligible;
    logic [NB-1:0]      set_vec;
    logic [NB-1:0]      w1c;
    logic [NB-1:0]      ack_clr;
    logic [3:0]         winner;
    logic               wr_mask;
    logic               wr_pend;
    logic               unused_din;

    assign rise     = irq_src & ~irq_q;
    assign ack_rise = bus.int_ack & ~ack_q;
    assign eligible = pend & mask;
    assign wr_mask  = bus.cfg_wr && (bus.cfg_addr == 2'd0);
    assign wr_pend  = bus.cfg_wr && (bus.cfg_addr == 2'd1);
    assign w1c      = wr_pend ? bus.cfg_din[NB-1:0] : '0;
    assign unused_din = ^bus.cfg_din;

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        winner = 4'd0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 4'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NB; i++) begin
            ack_clr[i] = (state == ASSERT) && ack_rise && (int_id_q == 4'(i));
        end
    end

`ifdef IO_INTR_TIMER_EN
    logic [TIMER_W-1:0] tload;
    logic [TIMER_W-1:0] count;
    logic               ten;
    logic               arl;
    logic               wr_load;
    logic               wr_ctrl;
    logic               stop_wr;
    logic               run;
    logic               tmr_fire;

    assign wr_load  = bus.cfg_wr && (bus.cfg_addr == 2'd2);
    assign wr_ctrl  = bus.cfg_wr && (bus.cfg_addr == 2'd3);
    // A TEN=0 write halts the counter in the same cycle, so it also blocks a fire.
    assign stop_wr  = wr_ctrl && !bus.cfg_din[0];
    assign run      = ten && !stop_wr;
    assign tmr_fire = run && (count == TIMER_W'(1));
    assign set_vec  = {tmr_fire, rise};

    always_ff @(posedge clk) begin
        if (reset) begin
            tload <= TIMER_W'(TIMER_INIT);
            count <= '0;
            ten   <= 1'b0;
            arl   <= 1'b0;
        end else begin
            if (wr_load) tload <= bus.cfg_din[TIMER_W-1:0];

            if (wr_ctrl) begin
                ten <= bus.cfg_din[0];
                arl <= bus.cfg_din[1];
            end else if (tmr_fire && !arl) begin
                ten <= 1'b0;
            end

            // Reloading straight from 1 keeps the period at exactly TIMER_LOAD cycles.
            if (wr_ctrl && bus.cfg_din[0] && !ten) begin
                count <= tload;
            end else if (run && (count != '0)) begin
                if (count == TIMER_W'(1)) count <= arl ? tload : '0;
                else                      count <= count - TIMER_W'(1);
            end
        end
    end

    always_comb begin
        case (bus.cfg_addr)
            2'd0:    bus.cfg_dout = 32'(mask);
            2'd1:    bus.cfg_dout = 32'(pend);
            2'd2:    bus.cfg_dout = 32'(tload);
            default: bus.cfg_dout = {30'd0, arl, ten};
        endcase
    end
`else
    assign set_vec = rise;

    always_comb begin
        case (bus.cfg_addr)
            2'd0:    bus.cfg_dout = 32'(mask);
            2'd1:    bus.cfg_dout = 32'(pend);
            default: bus.cfg_dout = 32'd0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q    <= '0;
            ack_q    <= 1'b0;
            mask     <= '0;
            pend     <= '0;
            state    <= IDLE;
            intr_q   <= 1'b0;
            int_id_q <= 4'd0;
        end else begin
            irq_q <= irq_src;
            ack_q <= bus.int_ack;
            if (wr_mask) mask <= bus.cfg_din[NB-1:0];
            // New edges are OR-ed in last so they win over W1C and ack clears.
            pend <= (pend & ~w1c & ~ack_clr) | set_vec;

            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        int_id_q <= winner;
                        intr_q   <= 1'b1;
                        state    <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (ack_rise) begin
                        intr_q <= 1'b0;
                        state  <= GAP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.intr   = intr_q;
    assign bus.int_id = int_id_q;

endmodule

// File: tb/tb_io_intr_ctrl.sv
module tb_io_intr_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    int         vecs = 0;
    int         errs = 0;
    logic [31:0] d;

    io_intr_ctrl_if bus();

    io_intr_ctrl #(.NUM_SRC(4), .TIMER_W(16), .TIMER_INIT(1000)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.cfg_wr   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_din  = v;
        step();
        bus.cfg_wr   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.cfg_addr = a;
        #1;
        v = bus.cfg_dout;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_src = '0;
        bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_din = '0; bus.int_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        vecs++; if (bus.intr !== 1'b0) begin errs++; $display("FAIL reset_intr got %0h want 0", bus.intr); end
        vecs++; if (bus.int_id !== 4'd0) begin errs++; $display("FAIL reset_id got %0h want 0", bus.int_id); end
        rd(2'd0, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL reset_mask got %0h want 0", d); end
        rd(2'd1, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL reset_pend got %0h want 0", d); end
`ifdef IO_INTR_TIMER_EN
        rd(2'd2, d);
        vecs++; if (d !== 32'd1000) begin errs++; $display("FAIL reset_tload got %0h want 3e8", d); end
`endif
    endtask

    task automatic test_single();
        wr(2'd0, 32'h1);
        irq_src = 4'h1;
        step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h1) begin errs++; $display("FAIL single_pend got %0h want 1", d); end
        vecs++; if (bus.intr !== 1'b0) begin errs++; $display("FAIL single_early got %0h want 0", bus.intr); end
        step();
        vecs++; if (bus.intr !== 1'b1 || bus.int_id !== 4'd0) begin errs++; $display("FAIL single_intr got %0h/%0h want 1/0", bus.intr, bus.int_id); end
        irq_src = 4'h0;
        bus.int_ack = 1'b1;
        step();
        rd(2'd1, d);
        vecs++; if (bus.intr !== 1'b0 || d !== 32'h0) begin errs++; $display("FAIL single_ack got %0h/%0h want 0/0", bus.intr, d); end
        bus.int_ack = 1'b0;
        step(); step();
    endtask

    task automatic test_priority();
        wr(2'd0, 32'hF);
        irq_src = 4'h6;
        step();
        irq_src = 4'h0;
        step();
        vecs++; if (bus.intr !== 1'b1 || bus.int_id !== 4'd1) begin errs++; $display("FAIL prio_first got %0h/%0h want 1/1", bus.intr, bus.int_id); end
        bus.int_ack = 1'b1;
        step();
        rd(2'd1, d);
        vecs++; if (bus.intr !== 1'b0 || d !== 32'h4) begin errs++; $display("FAIL prio_ack got %0h/%0h want 0/4", bus.intr, d); end
        bus.int_ack = 1'b0;
        step();
        vecs++; if (bus.intr !== 1'b0) begin errs++; $display("FAIL prio_gap got %0h want 0", bus.intr); end
        step();
        vecs++; if (bus.intr !== 1'b1 || bus.int_id !== 4'd2) begin errs++; $display("FAIL prio_second got %0h/%0h want 1/2", bus.intr, bus.int_id); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step(); step();
    endtask

    task automatic test_mask();
        wr(2'd0, 32'h0);
        irq_src = 4'h8;
        step();
        irq_src = 4'h0;
        rd(2'd1, d);
        vecs++; if (d !== 32'h8) begin errs++; $display("FAIL mask_pend got %0h want 8", d); end
        step(); step();
        vecs++; if (bus.intr !== 1'b0) begin errs++; $display("FAIL mask_blocked got %0h want 0", bus.intr); end
        wr(2'd0, 32'h8);
        step();
        vecs++; if (bus.intr !== 1'b1 || bus.int_id !== 4'd3) begin errs++; $display("FAIL mask_enable got %0h/%0h want 1/3", bus.intr, bus.int_id); end
        wr(2'd0, 32'h0);
        vecs++; if (bus.intr !== 1'b1) begin errs++; $display("FAIL mask_hold got %0h want 1", bus.intr); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step(); step();
    endtask

    task automatic test_w1c();
        irq_src = 4'h1;
        step();
        irq_src = 4'h0;
        step();
        wr(2'd1, 32'h1);
        rd(2'd1, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL w1c_plain got %0h want 0", d); end
        irq_src = 4'h1;
        wr(2'd1, 32'h1);
        rd(2'd1, d);
        vecs++; if (d !== 32'h1) begin errs++; $display("FAIL w1c_edge_wins got %0h want 1", d); end
        wr(2'd1, 32'h1);
        step(); step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL w1c_held_once got %0h want 0", d); end
        irq_src = 4'h0;
        step();
    endtask

    task automatic test_ack_held();
        wr(2'd0, 32'h3);
        irq_src = 4'h3;
        step();
        irq_src = 4'h0;
        step();
        vecs++; if (bus.intr !== 1'b1 || bus.int_id !== 4'd0) begin errs++; $display("FAIL held_first got %0h/%0h want 1/0", bus.intr, bus.int_id); end
        bus.int_ack = 1'b1;
        step();
        vecs++; if (bus.intr !== 1'b0) begin errs++; $display("FAIL held_ack got %0h want 0", bus.intr); end
        step(); step();
        vecs++; if (bus.intr !== 1'b1 || bus.int_id !== 4'd1) begin errs++; $display("FAIL held_second got %0h/%0h want 1/1", bus.intr, bus.int_id); end
        step(); step(); step();
        rd(2'd1, d);
        vecs++; if (bus.intr !== 1'b1 || d !== 32'h2) begin errs++; $display("FAIL held_no_reack got %0h/%0h want 1/2", bus.intr, d); end
        bus.int_ack = 1'b0;
        step();
        bus.int_ack = 1'b1;
        step();
        rd(2'd1, d);
        vecs++; if (bus.intr !== 1'b0 || d !== 32'h0) begin errs++; $display("FAIL held_reack got %0h/%0h want 0/0", bus.intr, d); end
        bus.int_ack = 1'b0;
        wr(2'd0, 32'h0);
        step();
    endtask

`ifdef IO_INTR_TIMER_EN
    task automatic test_timer();
        wr(2'd0, 32'h10);
        wr(2'd2, 32'd5);
        wr(2'd3, 32'h3);
        repeat (4) step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL tmr_early got %0h want 0", d); end
        step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h10) begin errs++; $display("FAIL tmr_fire1 got %0h want 10", d); end
        step();
        vecs++; if (bus.intr !== 1'b1 || bus.int_id !== 4'd4) begin errs++; $display("FAIL tmr_intr got %0h/%0h want 1/4", bus.intr, bus.int_id); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step(); step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL tmr_period_early got %0h want 0", d); end
        step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h10) begin errs++; $display("FAIL tmr_fire2 got %0h want 10", d); end
        step();
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        wr(2'd3, 32'h0);
        wr(2'd0, 32'h0);
        wr(2'd2, 32'd3);
        wr(2'd3, 32'h1);
        repeat (3) step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h10) begin errs++; $display("FAIL tmr_single_fire got %0h want 10", d); end
        rd(2'd3, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL tmr_ten_clear got %0h want 0", d); end
        wr(2'd1, 32'h10);
        repeat (6) step();
        rd(2'd1, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL tmr_no_refire got %0h want 0", d); end
    endtask
`else
    task automatic test_no_timer();
        wr(2'd2, 32'h1234);
        wr(2'd3, 32'h3);
        rd(2'd2, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL notmr_load got %0h want 0", d); end
        rd(2'd3, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL notmr_ctrl got %0h want 0", d); end
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, d);
        vecs++; if (d !== 32'hF) begin errs++; $display("FAIL notmr_mask_width got %0h want f", d); end
        repeat (8) step();
        vecs++; if (bus.intr !== 1'b0) begin errs++; $display("FAIL notmr_quiet got %0h want 0", bus.intr); end
        wr(2'd0, 32'h0);
    endtask
`endif

    task automatic test_reset_mid();
        wr(2'd2, 32'd7);
        wr(2'd0, 32'h1);
        irq_src = 4'h1;
        step(); step();
        vecs++; if (bus.intr !== 1'b1) begin errs++; $display("FAIL rst_mid_setup got %0h want 1", bus.intr); end
        reset = 1'b1;
        irq_src = 4'h0;
        step();
        reset = 1'b0;
        vecs++; if (bus.intr !== 1'b0 || bus.int_id !== 4'd0) begin errs++; $display("FAIL rst_mid_intr got %0h/%0h want 0/0", bus.intr, bus.int_id); end
        rd(2'd1, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL rst_mid_pend got %0h want 0", d); end
        rd(2'd0, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL rst_mid_mask got %0h want 0", d); end
`ifdef IO_INTR_TIMER_EN
        rd(2'd2, d);
        vecs++; if (d !== 32'd1000) begin errs++; $display("FAIL rst_mid_tload got %0h want 3e8", d); end
`endif
        step(); step();
        vecs++; if (bus.intr !== 1'b0) begin errs++; $display("FAIL rst_mid_stays_low got %0h want 0", bus.intr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_w1c();
        test_ack_held();
`ifdef IO_INTR_TIMER_EN
        test_timer();
`else
        test_no_timer();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
